// File: rtl/cpu_defs.sv
// Shared CPU constants: exception code width, fetch-exception flag bit, reset PC.
package cpu_defs;

    localparam int          EXC_W       = 7;
    localparam int          EXC_VLD_BIT = EXC_W - 1;
    localparam logic [31:0] RESET_PC    = 32'hbfc0_0000;

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for the decode instruction queue; push and response write ports, async read.
// Writes land on the next rising edge, reads are combinational; no backpressure of its own.
module inst_queue_ram #(
    parameter int DEPTH = 4,
    parameter int EXC_W = cpu_defs::EXC_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             push_en,
    input  logic [AW-1:0]    push_addr,
    input  logic [31:0]      push_pc,
    input  logic [EXC_W-1:0] push_exc,
    input  logic [31:0]      push_badvaddr,
    input  logic             resp_en,
    input  logic [AW-1:0]    resp_addr,
    input  logic [31:0]      resp_inst,
    input  logic [AW-1:0]    rd_addr,
    output logic [31:0]      rd_pc,
    output logic [EXC_W-1:0] rd_exc,
    output logic [31:0]      rd_badvaddr,
    output logic [31:0]      rd_inst
);

    logic [31:0]      pc_mem   [DEPTH];
    logic [EXC_W-1:0] exc_mem  [DEPTH];
    logic [31:0]      bad_mem  [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push_en) begin
            pc_mem[push_addr]   <= push_pc;
            exc_mem[push_addr]  <= push_exc;
            bad_mem[push_addr]  <= push_badvaddr;
            inst_mem[push_addr] <= '0;
        end
        // push and response never target the same slot: a response only fills a pending entry
        if (resp_en) begin
            inst_mem[resp_addr] <= resp_inst;
        end
    end

    assign rd_pc       = pc_mem[rd_addr];
    assign rd_exc      = exc_mem[rd_addr];
    assign rd_badvaddr = bad_mem[rd_addr];
    assign rd_inst     = inst_mem[rd_addr];

endmodule

// File: rtl/decode_inst_queue.sv
// Fetch-to-decode instruction queue pairing in-order responses with pending entries, flush-safe.
// Response/exception push -> de_valid next cycle; fe_allowin drops when full or flushing.
module decode_inst_queue #(
    parameter int DEPTH = 4,
    parameter int EXC_W = cpu_defs::EXC_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fe_valid,
    input  logic [31:0]                fe_pc,
    input  logic [EXC_W-1:0]           fe_exc,
    input  logic [31:0]                fe_badvaddr,
    output logic                       fe_allowin,
    input  logic                       inst_data_ok,
    input  logic [31:0]                inst_rdata,
    input  logic                       flush,
    output logic                       de_valid,
    input  logic                       de_ready,
    output logic [31:0]                de_pc,
    output logic [31:0]                de_inst,
    output logic [EXC_W-1:0]           de_exc,
    output logic [31:0]                de_badvaddr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    head, fill, tail, fill_nxt, tail_nxt;
    logic [CW-1:0]    disc, pend, pend_nxt, flush_disc;
    logic [CW:0]      disc_sum;
    logic [DEPTH-1:0] done, done_nxt;
    logic             found;
    logic             push, push_pend, pop, resp_drop, resp_fill;
    logic [31:0]      rd_pc, rd_inst, rd_bad;
    logic [EXC_W-1:0] rd_exc;

    assign fe_allowin = (count < CW'(DEPTH)) && !flush;
    assign de_valid   = (count != '0) && done[head];

    assign push      = fe_valid && fe_allowin;
    assign push_pend = push && !fe_exc[EXC_W-1];
    assign pop       = de_valid && de_ready && !flush;
    assign resp_drop = inst_data_ok && (disc != '0);
    assign resp_fill = inst_data_ok && (disc == '0) && (pend != '0) && !flush;

    always_comb begin
        done_nxt = done;
        if (pop)       done_nxt[head] = 1'b0;
        if (resp_fill) done_nxt[fill] = 1'b1;
        if (push)      done_nxt[tail] = fe_exc[EXC_W-1];

        tail_nxt = tail + PW'(push);
        pend_nxt = pend + CW'(push_pend) - CW'(resp_fill);

        // slots past tail are free and carry done=0, so the first clear flag from fill is the oldest pending entry
        fill_nxt = tail_nxt;
        found    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && (pend_nxt != '0) && !done_nxt[fill + PW'(k)]) begin
                fill_nxt = fill + PW'(k);
                found    = 1'b1;
            end
        end

        disc_sum = {1'b0, disc} + {1'b0, pend};
        if (inst_data_ok && (disc_sum != '0)) disc_sum = disc_sum - (CW+1)'(1);
        flush_disc = (disc_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : disc_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            fill  <= '0;
            tail  <= '0;
            count <= '0;
            disc  <= '0;
            pend  <= '0;
            done  <= '0;
        end else if (flush) begin
            head  <= '0;
            fill  <= '0;
            tail  <= '0;
            count <= '0;
            pend  <= '0;
            done  <= '0;
            disc  <= flush_disc;
        end else begin
            head  <= head + PW'(pop);
            fill  <= fill_nxt;
            tail  <= tail_nxt;
            count <= count + CW'(push) - CW'(pop);
            pend  <= pend_nxt;
            done  <= done_nxt;
            disc  <= disc - CW'(resp_drop);
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .EXC_W (EXC_W),
        .AW    (PW)
    ) u_ram (
        .clk           (clk),
        .push_en       (push),
        .push_addr     (tail),
        .push_pc       (fe_pc),
        .push_exc      (fe_exc),
        .push_badvaddr (fe_badvaddr),
        .resp_en       (resp_fill),
        .resp_addr     (fill),
        .resp_inst     (inst_rdata),
        .rd_addr       (head),
        .rd_pc         (rd_pc),
        .rd_exc        (rd_exc),
        .rd_badvaddr   (rd_bad),
        .rd_inst       (rd_inst)
    );

    assign de_pc       = de_valid ? rd_pc   : '0;
    assign de_inst     = de_valid ? rd_inst : '0;
    assign de_exc      = de_valid ? rd_exc  : '0;
    assign de_badvaddr = de_valid ? rd_bad  : '0;

endmodule
